shift_issue_stage: RTL
======================

// Module: shift_issue_stage
// PURPOSE
//  Execute-issue register feeding the 32-bit barrel shift unit (rs1/rs2 -> rd).
//  Accepts decoded shift ops and resolves operand forwarding.
//  Selects the shift amount from either the register or the immediate.
//  Buffers operands in a 2-entry skid so that shifter back-pressure never creates a combinational ready path.
// PARAMETERS
//  XLEN     32  operand width
//  SHAMT_W  5   shift-amount width (log2 XLEN)
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_ni           in   1     asynchronous reset, active low
//  flush_i          in   1     pipeline flush (branch/trap)
//  in_valid_i       in   1     decoded shift op valid
//  in_ready_o       out  1     stage can accept
//  in_op_i          in   2     shift_op_e: SLL=0, SRL=1, SRA=2, 3=reserved
//  in_use_imm_i     in   1     1: shamt from in_imm_i, 0: from rs2
//  in_imm_i         in   5     immediate shamt
//  in_rs1_addr_i    in   5     source 1 index
//  in_rs2_addr_i    in   5     source 2 index
//  in_rd_addr_i     in   5     destination index
//  in_rs1_data_i    in   XLEN  regfile read data, source 1
//  in_rs2_data_i    in   XLEN  regfile read data, source 2
//  fwd_mem_we_i     in   1     MEM-stage result valid for forwarding
//  fwd_mem_addr_i   in   5     MEM-stage destination index
//  fwd_mem_data_i   in   XLEN  MEM-stage result
//  fwd_wb_we_i      in   1     WB-stage result valid for forwarding
//  fwd_wb_addr_i    in   5     WB-stage destination index
//  fwd_wb_data_i    in   XLEN  WB-stage result
//  out_valid_o      out  1     operands valid to shifter
//  out_ready_i      in   1     shifter/EX accepts
//  out_op_o         out  2     shift op
//  out_rs1_o        out  XLEN  value to shift
//  out_rs2_o        out  XLEN  {27'b0, shamt}
//  out_rd_addr_o    out  5     destination index
// BEHAVIOUR
//  - Reset (rst_ni=0, async): both entries invalid, all payload regs 0.
//    Outputs: out_valid_o=0, out_* = 0, in_ready_o=1.
//  - Handshakes: transfer when valid&ready on the rising edge.
//    out_valid_o must not drop and out_* must not change until out_ready_i=1.
//  - Latency 1 cycle: input accepted at edge N appears on out_* after edge N.
//  - Storage: main entry (drives out_*) plus skid entry.
//    in_ready_o = ~skid_valid, registered; no combinational path from out_ready_i.
//    Skid fills when input is accepted while main is valid and !out_ready_i.
//    On drain, skid moves to main in the same edge the main transfers.
//    Order is strictly FIFO.
//  - Simultaneous accept and drain with main valid and skid empty: new op goes to main; skid stays empty.
//  - Forwarding is resolved once, at acceptance; entries hold resolved values.
//    Per source: MEM match > WB match > regfile.
//    Match = we & addr==src_addr & src_addr!=0.
//    x0 always reads 0, regardless of regfile data.
//  - Shamt = in_use_imm_i ? in_imm_i : rs2_resolved[4:0].
//    out_rs2_o zero-extends the shamt; upper rs2 bits are discarded.
//  - Reserved op 3 is stored as SLL (0).
//  - Flush:
//    - Clears main and skid valid at the next edge.
//    - Any input offered in the same cycle is dropped, even if in_ready_o=1.
//    - in_ready_o=1 on the cycle after the flush.
//    - Payload registers are not cleared by flush.
//  - Flush and out_ready_i in the same cycle: the output transfer counts; both entries are then invalid.
//  - Reset mid-operation: immediate return to reset state; no op survives.
// CONFIGURATION
//  SHIFT_ISSUE_FWD_EN:
//    defined   -> MEM/WB forwarding as above.
//    undefined -> fwd_* ports remain but are ignored; operands come from regfile data, with x0 forced to 0.
//                 The hazard unit stalls instead.
// STRUCTURE
//  - shift_pkg: XLEN, SHAMT_W, shift_op_e enum, shift_issue_t struct {op, rs1, rs2, rd}.
//    The shifter and the ALU share this package.
//  - Sub-module operand_fwd_mux: one instance per source.
//    Inputs: src_addr, rf_data, mem/wb we/addr/data. Output: resolved data.
//    Purely combinational; contains the SHIFT_ISSUE_FWD_EN ifdef.
//  - Top level: skid control and the two shift_issue_t registers.
// TESTING
//  1. Reset mid-stream:
//     stimulus -> assert rst_ni=0 with 2 entries held.
//     required -> out_valid_o=0 and in_ready_o=1 immediately, before any clock edge.
//  2. Forward priority:
//     stimulus -> rs1=x5, regfile data 0x1, WB x5=0x2, MEM x5=0x3.
//     required -> out_rs1_o=0x3.
//     stimulus -> rs1=x0 with MEM x0=0xFF.
//     required -> out_rs1_o=0.
//  3. Immediate shamt:
//     stimulus -> SRA, use_imm=1, imm=31, rs2 data 0xFFFF_FFE3.
//     required -> out_rs2_o=0x1F, out_op_o=2.
//     stimulus -> same with use_imm=0.
//     required -> out_rs2_o=0x03.
//  4. Back-pressure:
//     stimulus -> out_ready_i=0, offer A,B,C back-to-back.
//     required -> A in main, B in skid, in_ready_o=0 and C held.
//     stimulus -> release out_ready_i.
//     required -> A,B,C emerge in order with no loss or duplicates.
//  5. Flush with both entries full plus an offered op D:
//     required -> next cycle out_valid_o=0, in_ready_o=1, and D never appears.
//  6. Random valid/ready stress, 10k ops:
//     required -> scoreboard matches golden forwarding/shamt model, and the
//                 out_* stability assertion holds while out_valid_o & !out_ready_i.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the shift issue stage, the barrel shifter and the ALU.
// Defines operand widths, the shift opcode enum and the issued-op payload struct.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int REG_W   = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_RSV = 2'd3
  } shift_op_e;

  typedef struct packed {
    shift_op_e        op;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [REG_W-1:0] rd;
  } shift_issue_t;

  // The reserved encoding is folded onto SLL so the shifter never sees it.
  function automatic shift_op_e legalize_op(logic [1:0] raw);
    return (raw == 2'd3) ? SHIFT_SLL : shift_op_e'(raw);
  endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Decode-side, forwarding and shifter-side signals of the shift issue stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
// once valid is raised the sender holds valid and payload unchanged until it sees ready.
interface shift_issue_if
  import shift_pkg::*;
();

  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        in_op_i;
  logic              in_use_imm_i;
  logic [SHAMT_W-1:0] in_imm_i;
  logic [REG_W-1:0]  in_rs1_addr_i;
  logic [REG_W-1:0]  in_rs2_addr_i;
  logic [REG_W-1:0]  in_rd_addr_i;
  logic [XLEN-1:0]   in_rs1_data_i;
  logic [XLEN-1:0]   in_rs2_data_i;
  logic              fwd_mem_we_i;
  logic [REG_W-1:0]  fwd_mem_addr_i;
  logic [XLEN-1:0]   fwd_mem_data_i;
  logic              fwd_wb_we_i;
  logic [REG_W-1:0]  fwd_wb_addr_i;
  logic [XLEN-1:0]   fwd_wb_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [1:0]        out_op_o;
  logic [XLEN-1:0]   out_rs1_o;
  logic [XLEN-1:0]   out_rs2_o;
  logic [REG_W-1:0]  out_rd_addr_o;

  modport master (
    output in_valid_i, in_op_i, in_use_imm_i, in_imm_i,
           in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i, in_rs1_data_i, in_rs2_data_i,
           fwd_mem_we_i, fwd_mem_addr_i, fwd_mem_data_i,
           fwd_wb_we_i, fwd_wb_addr_i, fwd_wb_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_op_o, out_rs1_o, out_rs2_o, out_rd_addr_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_use_imm_i, in_imm_i,
           in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i, in_rs1_data_i, in_rs2_data_i,
           fwd_mem_we_i, fwd_mem_addr_i, fwd_mem_data_i,
           fwd_wb_we_i, fwd_wb_addr_i, fwd_wb_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_op_o, out_rs1_o, out_rs2_o, out_rd_addr_o
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: MEM result, then WB result, then regfile; x0 always reads 0.
// With SHIFT_ISSUE_FWD_EN undefined the forwarding inputs are ignored (the hazard unit stalls).
module operand_fwd_mux
  import shift_pkg::*;
(
  input  logic [REG_W-1:0] src_addr_i,
  input  logic [XLEN-1:0]  rf_data_i,
  input  logic             mem_we_i,
  input  logic [REG_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic             wb_we_i,
  input  logic [REG_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic [XLEN-1:0]  data_o
);

  logic src_is_x0;
  assign src_is_x0 = (src_addr_i == '0);

`ifdef SHIFT_ISSUE_FWD_EN
  logic mem_hit;
  logic wb_hit;
  assign mem_hit = mem_we_i && (mem_addr_i == src_addr_i);
  assign wb_hit  = wb_we_i  && (wb_addr_i  == src_addr_i);

  always_comb begin
    data_o = rf_data_i;
    if (src_is_x0)    data_o = '0;
    else if (mem_hit) data_o = mem_data_i;
    else if (wb_hit)  data_o = wb_data_i;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_we_i, mem_addr_i, mem_data_i, wb_we_i, wb_addr_i, wb_data_i};

  always_comb begin
    data_o = rf_data_i;
    if (src_is_x0) data_o = '0;
  end
`endif

endmodule

// File: rtl/shift_issue_stage.sv
// Execute-issue register for the barrel shifter: resolves operands at acceptance and
// buffers them in a main + skid pair so in_ready_o never depends on out_ready_i.
module shift_issue_stage
  import shift_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  shift_issue_if.slave bus
);

  logic [XLEN-1:0]    rs1_res;
  logic [XLEN-1:0]    rs2_res;
  logic [SHAMT_W-1:0] shamt;
  shift_issue_t       new_op;

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  shift_issue_t main_q, main_d;
  shift_issue_t skid_q, skid_d;

  logic accept;
  logic drain;

  operand_fwd_mux u_fwd_rs1 (
    .src_addr_i (bus.in_rs1_addr_i),
    .rf_data_i  (bus.in_rs1_data_i),
    .mem_we_i   (bus.fwd_mem_we_i),
    .mem_addr_i (bus.fwd_mem_addr_i),
    .mem_data_i (bus.fwd_mem_data_i),
    .wb_we_i    (bus.fwd_wb_we_i),
    .wb_addr_i  (bus.fwd_wb_addr_i),
    .wb_data_i  (bus.fwd_wb_data_i),
    .data_o     (rs1_res)
  );

  operand_fwd_mux u_fwd_rs2 (
    .src_addr_i (bus.in_rs2_addr_i),
    .rf_data_i  (bus.in_rs2_data_i),
    .mem_we_i   (bus.fwd_mem_we_i),
    .mem_addr_i (bus.fwd_mem_addr_i),
    .mem_data_i (bus.fwd_mem_data_i),
    .wb_we_i    (bus.fwd_wb_we_i),
    .wb_addr_i  (bus.fwd_wb_addr_i),
    .wb_data_i  (bus.fwd_wb_data_i),
    .data_o     (rs2_res)
  );

  // Only the low shamt bits of rs2 are meaningful to a shift.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^rs2_res[XLEN-1:SHAMT_W];

  assign shamt = bus.in_use_imm_i ? bus.in_imm_i : rs2_res[SHAMT_W-1:0];

  always_comb begin
    new_op.op  = legalize_op(bus.in_op_i);
    new_op.rs1 = rs1_res;
    new_op.rs2 = {{(XLEN-SHAMT_W){1'b0}}, shamt};
    new_op.rd  = bus.in_rd_addr_i;
  end

  assign accept = bus.in_valid_i && !skid_valid_q && !flush_i;
  assign drain  = main_valid_q && bus.out_ready_i;

  // Skid is only ever filled while main is stalled, so FIFO order is main before skid.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !drain) begin
      if (accept) begin
        skid_d       = new_op;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = new_op;
      main_valid_d = 1'b1;
    end else begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready_o    = !skid_valid_q;
  assign bus.out_valid_o   = main_valid_q;
  assign bus.out_op_o      = main_q.op;
  assign bus.out_rs1_o     = main_q.rs1;
  assign bus.out_rs2_o     = main_q.rs2;
  assign bus.out_rd_addr_o = main_q.rd;

endmodule
